// File: rtl/muldiv_unit.sv
// Iterative integer multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one iteration per cycle, with single-cycle fast paths for divide-by-zero and signed overflow.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  in1,
  input  logic [XLEN-1:0]  in2,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;

  logic [2:0]        op_r;
  logic [TAG_W-1:0]  tag_r;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc, mcand, acc_n, mcand_n, prod;
  logic [XLEN-1:0]   mplier, quot, remv, res, fast_res, mag1, mag2;
  logic [XLEN:0]     shifted, diff;
  logic              msign, negq, negr;
  logic              accept, is_div, sdiv, sgn1, sgn2, div_zero, div_ovf, fast;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready && !flush;

  always_comb begin
    is_div   = op[2];
    sdiv     = op[2] & ~op[0];
    sgn1     = (~op[2] & (op[1:0] != 2'b11)) | sdiv;
    sgn2     = (op[2:1] == 2'b00) | sdiv;
    mag1     = (sdiv && in1[XLEN-1]) ? -in1 : in1;
    mag2     = (sdiv && in2[XLEN-1]) ? -in2 : in2;
    div_zero = is_div && (in2 == '0);
    div_ovf  = sdiv && (in1 == {1'b1, {(XLEN-1){1'b0}}}) && (in2 == '1);
    fast     = div_zero || div_ovf;
    if (div_zero) fast_res = op[1] ? in1 : '1;
    else          fast_res = op[1] ? '0 : in1;
  end

  // acc holds the partial product, or {remainder, dividend/quotient} shifting left when dividing.
  always_comb begin
    shifted = acc[2*XLEN-1:XLEN-1];
    diff    = shifted - {1'b0, mcand[XLEN-1:0]};
    if (op_r[2]) begin
      mcand_n = mcand;
      acc_n   = diff[XLEN] ? {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                           : {diff[XLEN-1:0],    acc[XLEN-2:0], 1'b1};
    end else begin
      mcand_n = mcand << 1;
      acc_n   = mplier[0] ? acc + mcand : acc;
    end
    // Multiplier bit XLEN (its extension bit) carries weight -2^XLEN.
    prod = msign ? acc_n - mcand_n : acc_n;
    quot = acc_n[XLEN-1:0];
    remv = acc_n[2*XLEN-1:XLEN];
    case (op_r)
      3'd0:    res = prod[XLEN-1:0];
      3'd1,
      3'd2,
      3'd3:    res = prod[2*XLEN-1:XLEN];
      3'd4:    res = negq ? -quot : quot;
      3'd5:    res = quot;
      3'd6:    res = negr ? -remv : remv;
      default: res = remv;
    endcase
  end

  always_comb begin
    state_n = state;
    if (flush) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid) state_n = fast ? DONE : CALC;
        CALC:    if (cnt == LAST) state_n = DONE;
        DONE:    if (out_ready) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      out     <= '0;
      out_tag <= '0;
      op_r    <= '0;
      tag_r   <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      msign   <= 1'b0;
      negq    <= 1'b0;
      negr    <= 1'b0;
    end else if (accept) begin
      op_r   <= op;
      tag_r  <= in_tag;
      cnt    <= '0;
      negq   <= in1[XLEN-1] ^ in2[XLEN-1];
      negr   <= in1[XLEN-1];
      msign  <= sgn2 & in2[XLEN-1];
      mplier <= in2;
      if (is_div) begin
        acc   <= {{XLEN{1'b0}}, mag1};
        mcand <= {{XLEN{1'b0}}, mag2};
      end else begin
        acc   <= '0;
        mcand <= {{XLEN{sgn1 & in1[XLEN-1]}}, in1};
      end
      if (fast) begin
        out     <= fast_res;
        out_tag <= in_tag;
      end
    end else if (state == CALC && !flush) begin
      acc    <= acc_n;
      mcand  <= mcand_n;
      mplier <= mplier >> 1;
      if (cnt == LAST) begin
        out     <= res;
        out_tag <= tag_r;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at XLEN=32: arithmetic vectors, latency,
// backpressure, flush and reset aborts.
module tb_muldiv_unit;
  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [2:0]       op;
  logic [XLEN-1:0]  in1, in2, out;
  logic [TAG_W-1:0] in_tag, out_tag;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .in1(in1), .in2(in2), .in_tag(in_tag), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .out_tag(out_tag), .busy(busy)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vt [22] = '{
    '{3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 33},
    '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33},
    '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33},
    '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33},
    '{3'd2, 32'h80000000, 32'h00000002, 32'hFFFFFFFF, 33},
    '{3'd0, 32'h12345678, 32'h00000010, 32'h23456780, 33},
    '{3'd3, 32'h12345678, 32'h00000010, 32'h00000001, 33},
    '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33},
    '{3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33},
    '{3'd4, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 33},
    '{3'd6, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 33},
    '{3'd5, 32'h00000064, 32'h00000007, 32'h0000000E, 33},
    '{3'd7, 32'h00000064, 32'h00000007, 32'h00000002, 33},
    '{3'd5, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 1},
    '{3'd7, 32'h00000007, 32'h00000000, 32'h00000007, 1},
    '{3'd4, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1},
    '{3'd6, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 1},
    '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1},
    '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1},
    '{3'd5, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 33},
    '{3'd5, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33},
    '{3'd7, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33}
  };

  // Drives one request through the acceptance edge, then scrambles the inputs.
  task automatic send(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] t);
    op = o; in1 = a; in2 = b; in_tag = t; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; op = ~o; in1 = $urandom; in2 = $urandom; in_tag = ~t;
  endtask

  // k = index of the first edge after acceptance at which out_valid is sampled high.
  task automatic wait_valid(output int k);
    k = 1;
    while (!out_valid && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic release_out;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    op = '0; in1 = '0; in2 = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    total++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      bad++;
      $display("FAIL reset_ctrl: valid/busy/ready got %b want 001", {out_valid, busy, in_ready});
    end
    total++;
    if (out !== 32'h0 || out_tag !== 5'h0) begin
      bad++;
      $display("FAIL reset_data: out/tag got %h/%h want 0/0", out, out_tag);
    end
  endtask

  task automatic test_arith;
    int k;
    for (int i = 0; i < 22; i++) begin
      send(vt[i].op, vt[i].a, vt[i].b, TAG_W'(i));
      wait_valid(k);
      total++;
      if (k !== vt[i].lat) begin
        bad++;
        $display("FAIL latency[%0d]: got %0d want %0d", i, k, vt[i].lat);
      end
      total++;
      if (out !== vt[i].exp) begin
        bad++;
        $display("FAIL result[%0d] op=%0d: got %h want %h", i, vt[i].op, out, vt[i].exp);
      end
      total++;
      if (out_tag !== TAG_W'(i)) begin
        bad++;
        $display("FAIL tag[%0d]: got %0d want %0d", i, out_tag, i);
      end
      release_out();
      total++;
      if ({out_valid, in_ready} !== 2'b01) begin
        bad++;
        $display("FAIL handshake[%0d]: valid/ready got %b want 01", i, {out_valid, in_ready});
      end
    end
  endtask

  task automatic test_backpressure;
    int k;
    send(3'd0, 32'h7, 32'hFFFFFFFD, 5'd9);
    wait_valid(k);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      total++;
      if (!(out_valid === 1'b1 && in_ready === 1'b0 && out === 32'hFFFFFFEB && out_tag === 5'd9)) begin
        bad++;
        $display("FAIL hold[%0d]: valid=%b ready=%b out=%h tag=%0d want 1 0 ffffffeb 9",
                 c, out_valid, in_ready, out, out_tag);
      end
    end
    release_out();
    total++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      bad++;
      $display("FAIL bp_release: valid/busy/ready got %b want 001", {out_valid, busy, in_ready});
    end
    total++;
    if (out !== 32'hFFFFFFEB || out_tag !== 5'd9) begin
      bad++;
      $display("FAIL bp_idle_hold: out/tag got %h/%0d want ffffffeb/9", out, out_tag);
    end
  endtask

  task automatic test_flush;
    int seen = 0;
    send(3'd0, 32'h3, 32'h5, 5'd3);
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      bad++;
      $display("FAIL flush_idle: valid/busy/ready got %b want 001", {out_valid, busy, in_ready});
    end
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL flush_no_valid: valid cycles got %0d want 0", seen);
    end
    total++;
    if (out !== 32'hFFFFFFEB || out_tag !== 5'd9) begin
      bad++;
      $display("FAIL flush_hold: out/tag got %h/%0d want ffffffeb/9", out, out_tag);
    end
  endtask

  task automatic test_rst_mid;
    int seen = 0;
    send(3'd4, 32'h64, 32'h7, 5'd12);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if ({out_valid, busy, in_ready} !== 3'b001 || out !== 32'h0 || out_tag !== 5'h0) begin
      bad++;
      $display("FAIL rst_mid: valid/busy/ready=%b out=%h tag=%0d want 001 0 0",
               {out_valid, busy, in_ready}, out, out_tag);
    end
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL rst_no_valid: valid cycles got %0d want 0", seen);
    end
  endtask

  task automatic test_flush_accept;
    int k;
    op = 3'd5; in1 = 32'h7; in2 = 32'h0; in_tag = 5'd1;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    total++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      bad++;
      $display("FAIL flush_accept: valid/busy/ready got %b want 001", {out_valid, busy, in_ready});
    end
    send(3'd5, 32'h64, 32'h7, 5'd21);
    wait_valid(k);
    total++;
    if (k !== 33 || out !== 32'hE || out_tag !== 5'd21) begin
      bad++;
      $display("FAIL recover: lat=%0d out=%h tag=%0d want 33 e 21", k, out, out_tag);
    end
    release_out();
  endtask

  initial begin
    test_reset();
    test_arith();
    test_backpressure();
    test_flush();
    test_rst_mid();
    test_flush_accept();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32: operand and result width in bits; the block SHALL support any XLEN >= 8.
REQ-002 Parameter TAG_W, default 5: width of the tag that passes through unchanged (for example, the destination register index).
REQ-003 clk  input  1  the single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  a request is present.
REQ-006 in_ready  output  1  the block can accept a request.
REQ-007 op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-008 in1  input  XLEN  operand 1 (multiplicand or dividend).
REQ-009 in2  input  XLEN  operand 2 (multiplier or divisor).
REQ-010 in_tag  input  TAG_W  request tag.
REQ-011 flush  input  1  abort the operation in flight.
REQ-012 out_valid  output  1  a result is present.
REQ-013 out_ready  input  1  the consumer accepts the result.
REQ-014 out  output  XLEN  result.
REQ-015 out_tag  output  TAG_W  the tag of the request that produced the result.
REQ-016 busy  output  1  high whenever the state is not IDLE.

Function
REQ-017 The state machine SHALL have three states: IDLE, CALC and DONE.
REQ-018 in_ready SHALL equal (state == IDLE).
REQ-019 A request SHALL be accepted at a rising edge where in_valid && in_ready && !flush; the block captures op, in1, in2 and in_tag at that edge.
REQ-020 Normal path: an accepted request SHALL move IDLE -> CALC and run XLEN iterations, one per cycle, then move to DONE. With acceptance at edge t, out_valid SHALL be high from edge t+XLEN+1.
REQ-021 Multiply SHALL be radix-2 shift-add over a 2*XLEN-bit product.
- Operands SHALL be extended to XLEN+1 bits: sign-extended for signed operands, zero-extended for unsigned.
- MUL and MULH: signed x signed. MULHSU: signed in1 x unsigned in2. MULHU: unsigned x unsigned.
- MUL SHALL return product[XLEN-1:0]; MULH, MULHSU and MULHU SHALL return product[2*XLEN-1:XLEN].
REQ-022 Divide SHALL be restoring division on magnitudes.
- For DIV and REM, both operands SHALL be converted to magnitudes first.
- The quotient SHALL be negated when the operand signs differ.
- The remainder SHALL take the sign of the dividend.
- DIVU and REMU SHALL use the operands unmodified.
- DIV and DIVU SHALL return the quotient; REM and REMU SHALL return the remainder.
REQ-023 Fast path: divide by zero (in2 == 0, ops 4-7) SHALL bypass CALC and move IDLE -> DONE, with out_valid high from edge t+1. Results: DIV/DIVU all ones; REM/REMU in1.
REQ-024 Fast path: signed overflow (DIV or REM, in1 = 1 followed by XLEN-1 zeros, in2 = all ones) SHALL move IDLE -> DONE, with out_valid high from edge t+1. Results: DIV in1; REM 0.
REQ-025 In DONE, out_valid SHALL be 1, and out and out_tag SHALL stay stable until the handshake.
REQ-026 DONE SHALL move to IDLE at an edge where out_ready == 1. in_ready rises in the following cycle; there is no back-to-back overlap.
REQ-027 out_valid SHALL be 0 in IDLE and CALC.
REQ-028 out and out_tag SHALL hold their last values when out_valid == 0.
REQ-029 flush == 1 at an edge SHALL force IDLE from any state.
- The in-flight result is discarded and out_valid goes to 0.
- flush SHALL take priority over acceptance and over the out_ready handshake.
REQ-030 The iteration counter SHALL count 0..XLEN-1 and reset to 0 on every acceptance. It SHALL never wrap while in CALC.
REQ-031 Changes to in1, in2, op or in_tag after acceptance SHALL NOT affect the result.

Reset
REQ-032 While rst is high at an edge, the block SHALL force:
- state IDLE and iteration counter 0
- out_valid 0, out 0, out_tag 0, busy 0
- in_ready 1 from the next cycle.
REQ-033 rst SHALL take priority over flush, acceptance and the handshake.
REQ-034 rst asserted mid-operation SHALL discard the operation, and no out_valid SHALL follow.

Verification (XLEN=32)
REQ-035 MUL 7 x 0xFFFFFFFD, tag 5, accepted at edge t -> out 0xFFFFFFEB and out_tag 5, with out_valid high from edge t+33.
REQ-036 High-half products:
- MULH 0x80000000 x 0x80000000 -> 0x40000000
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE
- MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF
REQ-037 Signed division and divide by zero:
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF.
- DIVU 7 / 0 -> 0xFFFFFFFF; REMU 7 / 0 -> 7.
- The two divide-by-zero cases SHALL have out_valid high from edge t+1.
REQ-038 Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0. Both SHALL have out_valid high from edge t+1.
REQ-039 Backpressure: hold out_ready at 0 for 10 cycles in DONE -> out, out_tag and out_valid stay stable and in_ready stays 0. Then pulse out_ready for one cycle -> IDLE next cycle.
REQ-040 Abort:
- flush at the 5th CALC cycle -> IDLE at the next edge, with no out_valid afterwards.
- rst mid-CALC -> all outputs take their reset values.
- flush together with in_valid in IDLE -> request not accepted and busy stays 0.
